// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_half_sub.sv
// Combinational half-subtractor cell: diff = x - y (one bit), borrow when y > x.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic diff,
  output logic borrow
);

  assign diff   = x ^ y;
  assign borrow = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first) with start/busy/done handshake.
// Optional signed-overflow output `ovf` enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, res_q, res_d, diff_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               borrow_q, borrow_out_q;
  logic               last_bit;
  logic               hs1_diff, hs1_borrow, bit_d, hs2_borrow, bit_bout;

  half_subtractor u_hs1 (
    .x      (a_q[0]),
    .y      (b_q[0]),
    .diff   (hs1_diff),
    .borrow (hs1_borrow)
  );

  half_subtractor u_hs2 (
    .x      (hs1_diff),
    .y      (borrow_q),
    .diff   (bit_d),
    .borrow (hs2_borrow)
  );

  assign bit_bout = hs1_borrow | hs2_borrow;
  assign res_d    = {bit_d, res_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == IDLE && start) begin
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
    end else if (state_q == RUN && last_bit) begin
      // bit_d is the result MSB on the final processing cycle
      ovf_q <= (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
    end
  end

  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      diff_q       <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
          end
        end
        RUN: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          res_q    <= res_d;
          borrow_q <= bit_bout;
          cnt_q    <= cnt_q + CNT_W'(1);
          // Publish on the final bit so diff is valid in the DONE cycle
          if (last_bit) begin
            diff_q       <= res_d;
            borrow_out_q <= bit_bout;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=4 instances).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, borrow_out;
  logic [7:0] diff;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, borrow_out4;
  logic [3:0] diff4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

`ifdef SERIAL_SUB_OVF_EN
  logic ovf, ovf4;
`endif

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(borrow_out4)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf4)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation on the 8-bit instance and wait (bounded) for done.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                       output int lat, output int busy_n, output bit tmo);
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0; busy_n = 0; tmo = 1'b0;
    while (done !== 1'b1) begin
      if (busy === 1'b1) busy_n++;
      if (lat >= 40) begin tmo = 1'b1; break; end
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_checks++;
    if ({busy, done, borrow_out} !== 3'b000 || diff !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b diff=%h borrow=%b, want 0 0 00 0", busy, done, diff, borrow_out);
    end
`ifdef SERIAL_SUB_OVF_EN
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
  endtask

  task automatic test_basic();
    int lat, bn; bit tmo;
    do_op(8'd100, 8'd58, lat, bn, tmo);
    n_checks++;
    if (tmo || lat != 8) begin n_fail++; $display("FAIL basic_latency: got %0d tmo=%b want 8", lat, tmo); end
    n_checks++;
    if (bn != 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 8", bn); end
    n_checks++;
    if (diff !== 8'd42 || borrow_out !== 1'b0) begin
      n_fail++; $display("FAIL basic_result: diff=%0d borrow=%b want 42 0", diff, borrow_out);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || diff !== 8'd42) begin
      n_fail++; $display("FAIL basic_after_done: done=%b busy=%b diff=%0d want 0 0 42", done, busy, diff);
    end
  endtask

  task automatic test_underflow();
    int lat, bn; bit tmo;
    do_op(8'd3, 8'd5, lat, bn, tmo);
    n_checks++;
    if (tmo || diff !== 8'hFE || borrow_out !== 1'b1) begin
      n_fail++; $display("FAIL underflow: diff=%h borrow=%b tmo=%b want fe 1 0", diff, borrow_out, tmo);
    end
`ifdef SERIAL_SUB_OVF_EN
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL underflow_ovf: got %b want 0", ovf); end
`endif
    tick();
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    int lat, bn; bit tmo;
    do_op(8'h80, 8'h01, lat, bn, tmo);
    n_checks++;
    if (tmo || diff !== 8'h7F || borrow_out !== 1'b0 || ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_80_01: diff=%h borrow=%b ovf=%b want 7f 0 1", diff, borrow_out, ovf);
    end
    tick();
    do_op(8'h7F, 8'hFF, lat, bn, tmo);
    n_checks++;
    if (tmo || diff !== 8'h80 || borrow_out !== 1'b1 || ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_7f_ff: diff=%h borrow=%b ovf=%b want 80 1 1", diff, borrow_out, ovf);
    end
    tick();
  endtask
`endif

  task automatic test_ignore_start();
    int lat;
    a = 8'd100; b = 8'd58; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    a = 8'd1; b = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 3;
    while (done !== 1'b1 && lat < 40) begin tick(); lat++; end
    n_checks++;
    if (done !== 1'b1 || lat != 8) begin n_fail++; $display("FAIL ignore_latency: got %0d want 8", lat); end
    n_checks++;
    if (diff !== 8'd42 || borrow_out !== 1'b0) begin
      n_fail++; $display("FAIL ignore_result: diff=%0d borrow=%b want 42 0", diff, borrow_out);
    end
    tick(); tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_not_queued: busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int cyc, nd;
    int t[3];
    a = 8'd20; b = 8'd7; start = 1'b1;
    cyc = 0; nd = 0;
    while (nd < 3 && cyc < 100) begin
      tick();
      cyc++;
      if (done === 1'b1) begin
        t[nd] = cyc;
        nd++;
        n_checks++;
        if (diff !== 8'd13) begin n_fail++; $display("FAIL b2b_result: diff=%0d want 13", diff); end
        if (nd == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    n_checks++;
    if (nd != 3) begin
      n_fail++; $display("FAIL b2b_done_count: got %0d want 3", nd);
    end else begin
      n_checks++;
      if (t[1] - t[0] != 10 || t[2] - t[1] != 10) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d %0d want 10 10", t[1] - t[0], t[2] - t[1]);
      end
    end
    tick(); tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle_after: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bn; bit seen; bit tmo;
    a = 8'h55; b = 8'h0F; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({busy, done, borrow_out} !== 3'b000 || diff !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_state: busy=%b done=%b diff=%h borrow=%b want 0 0 00 0", busy, done, diff, borrow_out);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL midreset_quiet: activity=1 want 0"); end
    do_op(8'h55, 8'h0F, lat, bn, tmo);
    n_checks++;
    if (tmo || lat != 8 || diff !== 8'h46 || borrow_out !== 1'b0) begin
      n_fail++; $display("FAIL midreset_fresh: diff=%h borrow=%b lat=%0d want 46 0 8", diff, borrow_out, lat);
    end
    tick();
  endtask

  task automatic test_sweep_w4();
    int n;
    logic [3:0] ed;
    logic eb;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a4 = 4'(i); b4 = 4'(j); start4 = 1'b1;
        tick();
        start4 = 1'b0;
        n = 0;
        while (done4 !== 1'b1 && n < 20) begin tick(); n++; end
        ed = 4'((i - j) & 15);
        eb = (i < j);
        n_checks++;
        if (done4 !== 1'b1 || diff4 !== ed || borrow_out4 !== eb) begin
          n_fail++;
          $display("FAIL sweep a=%0d b=%0d: diff=%0d borrow=%b done=%b want %0d %b 1", i, j, diff4, borrow_out4, done4, ed, eb);
        end
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_sweep_w4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
